mem_handshake_responder: RTL
============================

Name: mem_handshake_responder

Overview:
- Memory-side responder for the CPU's valid/ack instruction and data channels.
- Owns a single-port word array.
- Accepts instruction fetches and data load/store requests, and returns read data after a programmable latency.
- Sits between the multi-cycle CPU and the testbench/SoC top as the far end of its Inst_Req, Inst, Mem_Req and Read_data handshakes.

Parameters:
- ADDR_W, 10, word-address width; array depth is 2^ADDR_W 32-bit words.
- INST_LAT, 1, wait cycles between request ack and Inst_Valid (0..15).
- DATA_LAT, 1, wait cycles between request ack and Read_data_Valid (0..15).

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- PC  in  32  instruction fetch byte address
- Inst_Req_Valid  in  1  fetch request
- Inst_Req_Ack  out  1  fetch request accepted (one-cycle pulse)
- Instruction  out  32  fetched word
- Inst_Valid  out  1  Instruction valid
- Inst_Ack  in  1  CPU consumed Instruction
- Address  in  32  data byte address
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Write_data  in  32  store data
- Write_strb  in  4  store byte enables; bit i covers byte lane i
- Mem_Req_Ack  out  1  data request accepted (one-cycle pulse)
- Read_data  out  32  load data
- Read_data_Valid  out  1  Read_data valid
- Read_data_Ack  in  1  CPU consumed Read_data

Behaviour:
- Reset: resetn is synchronous, active-low, clocked by clk.
  - All outputs reset to 0; both FSMs go to IDLE; latency counters clear.
  - Array contents are not reset.
  - Reset mid-operation drops any pending response; no partial write.
- Addressing: word index = addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored.
- Instruction FSM, states I_IDLE, I_ACK, I_WAIT, I_RESP:
  - I_IDLE: if Inst_Req_Valid=1 and no data grant this edge, latch array[PC] into Instruction and go to I_ACK.
  - I_ACK: Inst_Req_Ack=1 for exactly one cycle. Go to I_WAIT if INST_LAT>0, else I_RESP.
  - I_WAIT: count INST_LAT cycles, then go to I_RESP.
  - I_RESP: Inst_Valid=1; Instruction held stable. Return to I_IDLE on the edge where Inst_Ack=1. Inst_Valid drops the next cycle.
  - Minimum timing: request sampled at edge 0; Ack high in cycle 1; Valid high from cycle 2+INST_LAT.
- Data FSM, states D_IDLE, D_ACK, D_WAIT, D_RESP:
  - D_IDLE, MemWrite=1: write lanes selected by Write_strb into array[Address] on that edge, then go to D_ACK. D_ACK then returns to D_IDLE; no read response.
  - D_IDLE, MemRead=1 only: latch array[Address] into Read_data and go to D_ACK.
  - D_ACK (read): Mem_Req_Ack=1 for one cycle, then go to D_WAIT (DATA_LAT>0) or D_RESP.
  - D_RESP: Read_data_Valid=1 until the edge with Read_data_Ack=1.
  - MemRead and MemWrite both high: treated as a write only.
  - Write_strb=0 with MemWrite=1: acknowledged, array unchanged.
- Arbitration (single port):
  - The array is accessed only on acceptance edges.
  - If I_IDLE and D_IDLE both see requests on the same edge, the data request wins. The fetch stays pending and is accepted on the next edge.
  - A store followed by a fetch to the same word returns the new value.
- Requests arriving while an FSM is not IDLE are ignored, not queued. The CPU must hold Valid/MemRead/MemWrite until it sees the ack.
- Inst_Ack and Read_data_Ack are ignored outside their RESP states.
- Counters are 4 bits and saturate-free because latency is ≤ 15.

Optional Feature:
- MEM_RAND_LAT_EN defined:
  - 8-bit Fibonacci LFSR with taps 8,6,5,4, seed 8'hA5 at reset, advancing every cycle.
  - On each acceptance, the extra delay lfsr[1:0] (0..3) is added to INST_LAT or DATA_LAT for that transaction.
  - Separate snapshot per channel.
- MEM_RAND_LAT_EN undefined: LFSR is absent and latency is exactly the parameter.

Test Plan:
- Fetch with INST_LAT=1, array[3]=32'h2402_0005, PC=32'h0000_000C, Valid held → Inst_Req_Ack pulses in cycle 1. Inst_Valid rises in cycle 3 with Instruction=32'h2402_0005 and stays high 4 extra cycles while Inst_Ack=0. It falls one cycle after Inst_Ack=1.
- Store then load: MemWrite, Address=32'h10, Write_data=32'hDEAD_BEEF, strb=4'b0101; array[4] was 0 → Mem_Req_Ack pulses with no Read_data_Valid. A subsequent MemRead to 32'h10 returns 32'h00AD_00EF.
- Simultaneous requests: Inst_Req_Valid and MemRead high on the same edge → Mem_Req_Ack fires first, Inst_Req_Ack exactly one cycle later. Both responses carry the correct words.
- Reset mid-read: assert resetn=0 while in D_WAIT → next cycle all outputs are 0. After release, a fresh read completes normally and the array is intact.
- Ignored request: a second MemRead asserted while D_RESP is waiting for ack → no second Mem_Req_Ack until the first Read_data_Ack is given.
- MEM_RAND_LAT_EN: 100 back-to-back fetches with INST_LAT=1 → every Valid is observed 2..5 cycles after the ack, all data correct, and the delay sequence is identical across two runs.

Source files
------------

// File: rtl/mem_handshake_responder.sv
// Memory-side responder for the CPU instruction/data valid-ack channels over one single-port word array.
// Define MEM_RAND_LAT_EN to add a per-transaction LFSR-driven 0..3 cycle extra latency.
module mem_handshake_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned INST_LAT = 1,
    parameter int unsigned DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef MEM_RAND_LAT_EN
    localparam int unsigned CNT_W = 5;
`else
    localparam int unsigned CNT_W = 4;
`endif

    typedef enum logic [1:0] {I_IDLE, I_ACK, I_WAIT, I_RESP} i_state_t;
    typedef enum logic [1:0] {D_IDLE, D_ACK, D_WAIT, D_RESP} d_state_t;

    logic [31:0]       r_mem [DEPTH];
    i_state_t          r_i_state;
    d_state_t          r_d_state;
    logic [CNT_W-1:0]  r_i_cnt;
    logic [CNT_W-1:0]  r_d_cnt;
    logic              r_d_rd;

    logic [ADDR_W-1:0] w_pc_idx;
    logic [ADDR_W-1:0] w_d_idx;
    logic              w_d_grant;
    logic              w_d_write;
    logic              w_i_grant;
    logic [CNT_W-1:0]  w_i_lat;
    logic [CNT_W-1:0]  w_d_lat;
    logic              w_unused_addr;

    assign w_pc_idx  = PC[ADDR_W+1:2];
    assign w_d_idx   = Address[ADDR_W+1:2];
    assign w_d_grant = (r_d_state == D_IDLE) && (MemRead || MemWrite);
    assign w_d_write = w_d_grant && MemWrite;
    // Single port: a data request wins, the fetch is taken on a later edge.
    assign w_i_grant = (r_i_state == I_IDLE) && Inst_Req_Valid && !w_d_grant;
    assign w_unused_addr = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

`ifdef MEM_RAND_LAT_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_i_lat = CNT_W'(INST_LAT) + CNT_W'(r_lfsr[1:0]);
    assign w_d_lat = CNT_W'(DATA_LAT) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_i_lat = CNT_W'(INST_LAT);
    assign w_d_lat = CNT_W'(DATA_LAT);
`endif

    // Byte-lane store; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (resetn && w_d_write) begin
            for (int i = 0; i < 4; i++) begin
                if (Write_strb[i]) begin
                    r_mem[w_d_idx][8*i +: 8] <= Write_data[8*i +: 8];
                end
            end
        end
    end

    // Instruction channel; r_i_cnt holds the remaining wait cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_i_state    <= I_IDLE;
            r_i_cnt      <= '0;
            Inst_Req_Ack <= 1'b0;
            Inst_Valid   <= 1'b0;
            Instruction  <= '0;
        end else begin
            Inst_Req_Ack <= 1'b0;
            case (r_i_state)
                I_IDLE: begin
                    if (w_i_grant) begin
                        Instruction  <= r_mem[w_pc_idx];
                        r_i_cnt      <= w_i_lat;
                        Inst_Req_Ack <= 1'b1;
                        r_i_state    <= I_ACK;
                    end
                end
                I_ACK, I_WAIT: begin
                    if (r_i_cnt == '0) begin
                        Inst_Valid <= 1'b1;
                        r_i_state  <= I_RESP;
                    end else begin
                        r_i_cnt   <= r_i_cnt - CNT_W'(1);
                        r_i_state <= I_WAIT;
                    end
                end
                I_RESP: begin
                    if (Inst_Ack) begin
                        Inst_Valid <= 1'b0;
                        r_i_state  <= I_IDLE;
                    end
                end
                default: r_i_state <= I_IDLE;
            endcase
        end
    end

    // Data channel; stores finish after the ack cycle with no response
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_d_state       <= D_IDLE;
            r_d_cnt         <= '0;
            r_d_rd          <= 1'b0;
            Mem_Req_Ack     <= 1'b0;
            Read_data_Valid <= 1'b0;
            Read_data       <= '0;
        end else begin
            Mem_Req_Ack <= 1'b0;
            case (r_d_state)
                D_IDLE: begin
                    if (w_d_grant) begin
                        if (!MemWrite) begin
                            Read_data <= r_mem[w_d_idx];
                        end
                        r_d_rd      <= !MemWrite;
                        r_d_cnt     <= w_d_lat;
                        Mem_Req_Ack <= 1'b1;
                        r_d_state   <= D_ACK;
                    end
                end
                D_ACK, D_WAIT: begin
                    if (!r_d_rd) begin
                        r_d_state <= D_IDLE;
                    end else if (r_d_cnt == '0) begin
                        Read_data_Valid <= 1'b1;
                        r_d_state       <= D_RESP;
                    end else begin
                        r_d_cnt   <= r_d_cnt - CNT_W'(1);
                        r_d_state <= D_WAIT;
                    end
                end
                D_RESP: begin
                    if (Read_data_Ack) begin
                        Read_data_Valid <= 1'b0;
                        r_d_state       <= D_IDLE;
                    end
                end
                default: r_d_state <= D_IDLE;
            endcase
        end
    end

endmodule
